alu_arbiter: RTL and testbench

- Shares the single registered ALU between two requesters, e.g. the control-unit datapath and a secondary issuer (address/branch unit).
- Accepts operations over a valid/ready handshake and arbitrates round-robin.
- Drives the ALU's A, B and select inputs, holding them stable for a fixed multi-cycle window on multiply/divide.
- Captures the 64-bit {HI,LO} result and returns it with the requester ID over a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/rr_arb2.sv | 32 +++
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM states and op classifiers.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_NAND = 4'b1110;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Multiply and divide need the operands held for the multi-cycle window.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // NOP and the all-ones code never reach the ALU.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_BAD);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    // Grant a lone requester directly; on a tie the pointer decides.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant, favour the other requester next time.
    always_ff @(posedge clk) begin
        if (clear) begin
            ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: round-robin grant,
// operand hold for multi-cycle ops, and {HI,LO} result return.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op0,
    input  logic [3:0]           req_op1,
    input  logic [WIDTH-1:0]     req_a0,
    input  logic [WIDTH-1:0]     req_a1,
    input  logic [WIDTH-1:0]     req_b0,
    input  logic [WIDTH-1:0]     req_b1,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [3:0]           alu_sel,
    input  logic [2*WIDTH-1:0]   alu_out,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [2*WIDTH-1:0]   resp_result,
    output logic                 resp_err,
    output logic                 busy
);

    state_t             state;
    state_t             state_nx;
    logic [1:0]         grant;
    logic               advance;
    logic               gnt_id;
    logic [3:0]         gnt_op;
    logic [WIDTH-1:0]   gnt_a;
    logic [WIDTH-1:0]   gnt_b;
    logic [3:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   hold_last;

    rr_arb2 u_arb (
        .clk     (clk),
        .clear   (clear),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    // A grant only happens from IDLE and never in a reset cycle.
    assign advance   = (state == ST_IDLE) && !clear && (|grant);
    assign req_ready = advance ? grant : 2'b00;
    assign gnt_id    = grant[1];
    assign gnt_op    = gnt_id ? req_op1 : req_op0;
    assign gnt_a     = gnt_id ? req_a1  : req_a0;
    assign gnt_b     = gnt_id ? req_b1  : req_b0;
    assign hold_last = is_muldiv(op_q) ? CNT_W'(MULDIV_CYCLES - 1) : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx   = state;
        alu_sel    = OP_NOP;
        resp_valid = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (advance) begin
                    state_nx = is_illegal(gnt_op) ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_sel = op_q;
                if (cnt == hold_last) begin
                    state_nx = ST_CAPT;
                end
            end
            ST_CAPT: begin
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand latch, hold counter and result capture.
    always_ff @(posedge clk) begin
        if (clear) begin
            op_q        <= OP_NOP;
            cnt         <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            resp_id     <= 1'b0;
            resp_err    <= 1'b0;
            resp_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        op_q    <= gnt_op;
                        resp_id <= gnt_id;
                        cnt     <= '0;
                        if (is_illegal(gnt_op)) begin
                            // The ALU operands are left untouched for a rejected op.
                            resp_err    <= 1'b1;
                            resp_result <= '0;
                        end else begin
                            resp_err <= 1'b0;
                            alu_a    <= gnt_a;
                            alu_b    <= gnt_b;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                end
                ST_CAPT: begin
                    // Only mul/div write HI; for other ops HI is stale and masked.
                    if (is_muldiv(op_q)) begin
                        resp_result <= alu_out;
                    end else begin
                        resp_result <= {{WIDTH{1'b0}}, alu_out[WIDTH-1:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU and a
// scoreboard queue of expected responses.
module tb_alu_arbiter;

    localparam int W = 32;

    logic           clk;
    logic           clear;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [3:0]     req_op0, req_op1;
    logic [W-1:0]   req_a0, req_a1, req_b0, req_b1;
    logic [W-1:0]   alu_a, alu_b;
    logic [3:0]     alu_sel;
    logic [2*W-1:0] alu_out;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic [2*W-1:0] resp_result;
    logic           resp_err;
    logic           busy;

    alu_arbiter #(.WIDTH(W), .MULDIV_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .req_a0      (req_a0),
        .req_a1      (req_a1),
        .req_b0      (req_b0),
        .req_b1      (req_b1),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: simple ops only write LO, leaving HI stale.
    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
    endfunction

    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        sa = a;
        sb = b;
        if (sb == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    initial alu_out = '0;
    always @(posedge clk) begin
        case (alu_sel)
            4'h0: alu_out <= alu_out;
            4'h1: alu_out <= {alu_out[63:32], alu_a + alu_b};
            4'h2: alu_out <= {alu_out[63:32], alu_a - alu_b};
            4'h3: alu_out <= smul(alu_a, alu_b);
            4'h4: alu_out <= sdiv(alu_a, alu_b);
            4'h5: alu_out <= {alu_out[63:32], alu_a & alu_b};
            4'h6: alu_out <= {alu_out[63:32], alu_a | alu_b};
            4'h7: alu_out <= {alu_out[63:32], alu_a ^ alu_b};
            default: alu_out <= {alu_out[63:32], ~(alu_a & alu_b)};
        endcase
    end

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  stim_op  [2];
    logic [31:0] stim_a   [2];
    logic [31:0] stim_b   [2];
    logic [63:0] stim_res [2];
    logic        stim_err [2];
    logic [63:0] last_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit id, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] res, input logic err);
        stim_op[id]  = op;
        stim_a[id]   = a;
        stim_b[id]   = b;
        stim_res[id] = res;
        stim_err[id] = err;
        if (id) begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end
        req_valid[id] = 1'b1;
    endtask

    // Called at a negedge in IDLE: the grant must go to requester id.
    task automatic expect_grant(input bit id);
        exp_t e;
        #1;
        chk("grant", 64'(req_ready), 64'(2'b01 << id));
        e.id  = id;
        e.res = stim_res[id];
        e.err = stim_err[id];
        q.push_back(e);
    endtask

    // Follows an op from its grant negedge to the first negedge of RESP.
    task automatic finish_op(input bit id, input int exp_lat, input int exp_sel);
        int   lat = 0;
        int   sel_cnt = 0;
        int   sel_bad = 0;
        int   rdy_hits = 0;
        bit   seen = 0;
        exp_t e;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            lat = k;
            if (k == 1) begin
                chk("busy_after_grant", 64'(busy), 64'd1);
                req_valid[id] = 1'b0;
            end
            if (req_ready != 2'b00) rdy_hits++;
            if (alu_sel != 4'h0) begin
                sel_cnt++;
                if (alu_sel != stim_op[id] || alu_a != stim_a[id] || alu_b != stim_b[id])
                    sel_bad++;
            end
            if (resp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("resp_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("sel_cycles", 64'(sel_cnt), 64'(exp_sel));
        chk("sel_operands", 64'(sel_bad), 64'd0);
        chk("no_grant_busy", 64'(rdy_hits), 64'd0);
        if (seen && q.size() > 0) begin
            e = q.pop_front();
            chk("resp_id", 64'(resp_id), 64'(e.id));
            chk("resp_result", resp_result, e.res);
            chk("resp_err", 64'(resp_err), 64'(e.err));
            last_res = e.res;
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_sel"}, 64'(alu_sel), 64'd0);
        chk({tag, "_a"}, 64'(alu_a), 64'd0);
        chk({tag, "_b"}, 64'(alu_b), 64'd0);
        chk({tag, "_result"}, resp_result, 64'd0);
        chk({tag, "_err"}, 64'(resp_err), 64'd0);
        chk({tag, "_id"}, 64'(resp_id), 64'd0);
    endtask

    initial begin
        int vhits;
        clear = 1'b1; resp_ready = 1'b1; req_valid = 2'b00;
        req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        last_res = '0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        chk_idle_reset("reset");

        // Single simple op from requester 0.
        @(negedge clk);
        set_req(0, 4'h1, 32'd5, 32'd7, 64'h0000_0000_0000_000C, 1'b0);
        expect_grant(0);
        finish_op(0, 3, 1);

        // Mid-stream clear brings everything back to the reset picture (pointer to 0).
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_idle_reset("clear");

        // Simultaneous requests with pointer 0: req0 then req1.
        @(negedge clk);
        set_req(0, 4'h2, 32'h10, 32'h3, 64'h0000_0000_0000_000D, 1'b0);
        set_req(1, 4'h5, 32'hF0, 32'h3C, 64'h0000_0000_0000_0030, 1'b0);
        stim_a[0] = 32'd10; req_a0 = 32'd10; stim_res[0] = 64'd7;
        expect_grant(0);
        finish_op(0, 3, 1);
        @(negedge clk);
        expect_grant(1);
        finish_op(1, 3, 1);

        // Illegal op: error response straight from IDLE, ALU untouched.
        @(negedge clk);
        set_req(0, 4'hF, 32'h1234, 32'h5678, 64'd0, 1'b1);
        expect_grant(0);
        finish_op(0, 1, 0);

        // Simultaneous requests with pointer 1: multiply first, then OR with stale HI.
        @(negedge clk);
        set_req(1, 4'h3, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        set_req(0, 4'h6, 32'd1, 32'd2, 64'h0000_0000_0000_0003, 1'b0);
        expect_grant(1);
        finish_op(1, 6, 4);
        @(negedge clk);
        expect_grant(0);
        finish_op(0, 3, 1);

        // Back-pressure: response held 5 cycles while requester 1 waits.
        @(negedge clk);
        resp_ready = 1'b0;
        set_req(0, 4'h1, 32'd100, 32'd23, 64'h0000_0000_0000_007B, 1'b0);
        expect_grant(0);
        finish_op(0, 3, 1);
        set_req(1, 4'h7, 32'h0F, 32'hFF, 64'h0000_0000_0000_00F0, 1'b0);
        #1;
        chk("hold_ready0", 64'(req_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_result", resp_result, last_res);
            chk("hold_id", 64'(resp_id), 64'd0);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("handshake_no_grant", 64'(req_ready), 64'd0);
        @(negedge clk);
        expect_grant(1);
        finish_op(1, 3, 1);
        chk("queue_empty", 64'(q.size()), 64'd0);

        // Clear in the middle of a divide: no response may follow.
        @(negedge clk);
        set_req(1, 4'h4, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
        expect_grant(1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("div_sel", 64'(alu_sel), 64'(4'h4));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sel", 64'(alu_sel), 64'd0);
        chk("abort_valid", 64'(resp_valid), 64'd0);
        q.delete();
        vhits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) vhits++;
        end
        chk("abort_no_resp", 64'(vhits), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
